// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs : shared opcode, register and FSM encodings for the 16-bit CPU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_defs;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 5;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OPC_NOP   = 5'b00000;
  localparam opcode_t OPC_HALT  = 5'b00001;
  localparam opcode_t OPC_LOAD  = 5'b00010;
  localparam opcode_t OPC_STORE = 5'b00011;
  localparam opcode_t OPC_LDIH  = 5'b00100;
  localparam opcode_t OPC_ADD   = 5'b00101;
  localparam opcode_t OPC_ADDC  = 5'b00110;
  localparam opcode_t OPC_SUB   = 5'b00111;
  localparam opcode_t OPC_ADDI  = 5'b01000;
  localparam opcode_t OPC_SUBI  = 5'b01001;
  localparam opcode_t OPC_CMP   = 5'b01010;
  localparam opcode_t OPC_AND   = 5'b01011;
  localparam opcode_t OPC_OR    = 5'b01100;
  localparam opcode_t OPC_XOR   = 5'b01101;
  localparam opcode_t OPC_SLL   = 5'b01110;
  localparam opcode_t OPC_SRL   = 5'b01111;
  localparam opcode_t OPC_SRA   = 5'b10000;
  localparam opcode_t OPC_JUMP  = 5'b10001;
  localparam opcode_t OPC_JMPR  = 5'b10010;
  localparam opcode_t OPC_BZ    = 5'b10011;
  localparam opcode_t OPC_BNZ   = 5'b10100;
  localparam opcode_t OPC_BN    = 5'b10101;
  localparam opcode_t OPC_BNN   = 5'b10110;
  localparam opcode_t OPC_BC    = 5'b10111;
  localparam opcode_t OPC_BNC   = 5'b11000;
  localparam opcode_t OPC_NOR   = 5'b11001;
  localparam opcode_t OPC_NXOR  = 5'b11010;
  localparam opcode_t OPC_NAND  = 5'b11011;

  typedef enum logic [2:0] {
    GR0 = 3'd0, GR1 = 3'd1, GR2 = 3'd2, GR3 = 3'd3,
    GR4 = 3'd4, GR5 = 3'd5, GR6 = 3'd6, GR7 = 3'd7
  } gr_t;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_pc.sv
// ---------------------------------------------------------------------------
// fetch_pc : program counter with redirect / hold / increment next-pc mux
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_pc
  import cpu_defs::*;
#(
  parameter int PC_W = cpu_defs::PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            hold,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Redirect wins over hold so a wrong-path HALT or a stall can be flushed.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (hold) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : PC, instruction-memory address, IF/ID register, RUN/HALT FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import cpu_defs::*;
#(
  parameter int PC_W    = cpu_defs::PC_W,
  parameter int INSTR_W = cpu_defs::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted
);

  logic [0:0]         state_q;
  logic [0:0]         state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] instr_d;
  logic [PC_W-1:0]    ifpc_q;
  logic [PC_W-1:0]    ifpc_d;
  logic               valid_q;
  logic               valid_d;

  logic [PC_W-1:0]    pc;
  logic               in_halt;
  logic               halt_fetch;
  logic               pc_hold;

  assign in_halt    = (state_q == ST_HALT);
  assign halt_fetch = !in_halt && (imem_rdata[INSTR_W-1 -: OPC_W] == OPC_HALT);
  // The PC parks on the HALT address so a later resume sees a stable pc.
  assign pc_hold    = stall || in_halt || halt_fetch;

  fetch_pc #(
    .PC_W (PC_W)
  ) u_fetch_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (pc_hold),
    .pc          (pc)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    if (redirect) begin
      state_d = ST_RUN;
      instr_d = INSTR_W'(NOP_WORD);
      valid_d = 1'b0;
    end else if (stall) begin
      state_d = state_q;
    end else if (in_halt) begin
      instr_d = INSTR_W'(NOP_WORD);
      valid_d = 1'b0;
    end else begin
      instr_d = imem_rdata;
      ifpc_d  = pc;
      valid_d = 1'b1;
      state_d = halt_fetch ? ST_HALT : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      instr_q <= INSTR_W'(NOP_WORD);
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign halted      = in_halt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed vector table, randomized run against a model, async reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] if_id_instr;
  logic [7:0]  if_id_pc;
  logic        if_id_valid;
  logic        halted;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];

  fetch_stage #(.PC_W(8), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [7:0]  rpc;
    logic [7:0]  e_pc;
    logic [7:0]  e_ifpc;
    logic [15:0] e_instr;
    logic        e_valid;
    logic        e_halt;
  } vec_t;

  vec_t vq[$];

  // reference model state
  logic [7:0]  m_pc, m_ifpc;
  logic [15:0] m_instr;
  logic        m_valid, m_halt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [7:0] e_ifpc,
                           input logic [15:0] e_instr, input logic e_valid, input logic e_halt);
    chk({tag, ".pc"},    32'(imem_addr),   32'(e_pc));
    chk({tag, ".ifpc"},  32'(if_id_pc),    32'(e_ifpc));
    chk({tag, ".instr"}, 32'(if_id_instr), 32'(e_instr));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
    chk({tag, ".halt"},  32'(halted),      32'(e_halt));
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_ifpc = 8'h00; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  // Applies the fetch rules for one rising edge given the current inputs.
  task automatic model_edge();
    logic [15:0] w;
    w = mem[m_pc];
    if (redirect) begin
      m_pc = redirect_pc; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_halt) begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end else begin
      m_instr = w; m_ifpc = m_pc; m_valid = 1'b1;
      if (w[15:11] == 5'b00001) m_halt = 1'b1;
      else m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic add(input logic s, input logic r, input logic [7:0] rpc, input logic [7:0] pc,
                     input logic [7:0] ifpc, input logic [15:0] instr, input logic v, input logic h);
    vq.push_back('{s, r, rpc, pc, ifpc, instr, v, h});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h4123;
    mem[7] = 16'h0800;

    // free-run from reset
    add(0,0,8'h00, 8'h01,8'h00,16'h4123,1,0);
    add(0,0,8'h00, 8'h02,8'h01,16'h0000,1,0);
    add(0,0,8'h00, 8'h03,8'h02,16'h0000,1,0);
    add(0,0,8'h00, 8'h04,8'h03,16'h0000,1,0);
    for (int i = 0; i < 3; i++) add(1,0,8'h00, 8'h04,8'h03,16'h0000,1,0);
    add(0,0,8'h00, 8'h05,8'h04,16'h0000,1,0);
    add(0,0,8'h00, 8'h06,8'h05,16'h0000,1,0);
    // redirect during stall
    add(1,1,8'h01, 8'h01,8'h05,16'h0000,0,0);
    add(0,0,8'h00, 8'h02,8'h01,16'h0000,1,0);
    add(0,0,8'h00, 8'h03,8'h02,16'h0000,1,0);
    add(0,0,8'h00, 8'h04,8'h03,16'h0000,1,0);
    add(0,0,8'h00, 8'h05,8'h04,16'h0000,1,0);
    add(0,0,8'h00, 8'h06,8'h05,16'h0000,1,0);
    add(0,0,8'h00, 8'h07,8'h06,16'h0000,1,0);
    // HALT at 7, then frozen
    add(0,0,8'h00, 8'h07,8'h07,16'h0800,1,1);
    for (int i = 0; i < 10; i++) add(i == 4,0,8'h00, 8'h07,8'h07,16'h0000,0,1);
    // resume via redirect, then wrap 0xFF -> 0x00
    add(0,1,8'h02, 8'h02,8'h07,16'h0000,0,0);
    add(0,0,8'h00, 8'h03,8'h02,16'h0000,1,0);
    add(0,1,8'hFF, 8'hFF,8'h02,16'h0000,0,0);
    add(0,0,8'h00, 8'h00,8'hFF,16'h0000,1,0);
    add(0,0,8'h00, 8'h01,8'h00,16'h4123,1,0);

    #12;
    check_all("reset", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      stall = vq[i].stall; redirect = vq[i].redirect; redirect_pc = vq[i].rpc;
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_ifpc, vq[i].e_instr,
                vq[i].e_valid, vq[i].e_halt);
    end

    // randomized run with sprinkled HALT words
    for (int i = 0; i < 256; i++) begin
      mem[i] = ($urandom_range(0, 9) == 0) ? 16'h0800 : 16'($urandom);
    end
    stall = 1'b0; redirect = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 6) == 0);
      redirect_pc = 8'($urandom);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("rnd%0d", i), m_pc, m_ifpc, m_instr, m_valid, m_halt);
    end

    // asynchronous reset mid-cycle while running
    mem[0] = 16'h4123; mem[1] = 16'h0000; mem[2] = 16'h0000;
    stall = 1'b0; redirect = 1'b1; redirect_pc = 8'h00;
    @(posedge clk);
    redirect = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all("post_rst", m_pc, m_ifpc, m_instr, m_valid, m_halt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
